// File: rtl/vn_lut_loader.sv
// vn_lut_loader: streams one full LUT image from the host into a selected bank.
// Ports:
//   write_clk, rst        clock, asynchronous active-high reset
//   load_start, load_bank request to load a bank (bank sampled on acceptance)
//   load_abort            cancel an in-progress load
//   host_data/valid/ready host stream handshake
//   lut_in, write_addr    registered write data/address to the LUT RAMs
//   we_bank               registered one-hot-or-zero per-bank write enable
//   busy, done            load in progress / single-cycle completion pulse
//   bank_valid            per-bank "fully loaded" flags
module vn_lut_loader #(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 7,
    parameter int BANK_NUM = 8,
    localparam int BANK_W  = BANK_NUM > 1 ? $clog2(BANK_NUM) : 1
) (
    input  logic                write_clk,
    input  logic                rst,
    input  logic                load_start,
    input  logic [BANK_W-1:0]   load_bank,
    input  logic                load_abort,
    input  logic [DATA_W-1:0]   host_data,
    input  logic                host_valid,
    output logic                host_ready,
    output logic [DATA_W-1:0]   lut_in,
    output logic [ADDR_W-1:0]   write_addr,
    output logic [BANK_NUM-1:0] we_bank,
    output logic                busy,
    output logic                done,
    output logic [BANK_NUM-1:0] bank_valid
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    state_t              state_q;
    logic [BANK_W-1:0]   bank_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic [DATA_W-1:0]   lut_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BANK_NUM-1:0] we_q;
    logic [BANK_NUM-1:0] valid_q;
    logic                xfer;
    assign host_ready = state_q == LOAD;
    // An abort cycle never moves data, even if the host offers it.
    assign xfer       = host_ready && host_valid && !load_abort;
    assign busy       = state_q != IDLE;
    assign done       = state_q == DONE;
    assign lut_in     = lut_q;
    assign write_addr = addr_q;
    assign we_bank    = we_q;
    assign bank_valid = valid_q;
    always_ff @(posedge write_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bank_q  <= '0;
            cnt_q   <= '0;
            lut_q   <= '0;
            addr_q  <= '0;
            we_q    <= '0;
            valid_q <= '0;
        end else begin
            we_q <= '0;
            if (xfer) begin
                lut_q  <= host_data;
                addr_q <= cnt_q;
                we_q   <= BANK_NUM'(1) << bank_q;
                cnt_q  <= cnt_q + ADDR_W'(1);
            end
            case (state_q)
                IDLE: if (load_start) begin
                    bank_q             <= load_bank;
                    cnt_q              <= '0;
                    valid_q[load_bank] <= 1'b0;
                    state_q            <= LOAD;
                end
                LOAD: if (load_abort) state_q <= IDLE;
                      else if (xfer && cnt_q == '1) state_q <= DONE;
                // The final write is visible in DONE, so the bank is only
                // flagged valid once that write has landed.
                DONE: begin
                    valid_q[bank_q] <= 1'b1;
                    state_q         <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vn_lut_loader.sv
// tb_vn_lut_loader: randomized and directed checks of vn_lut_loader against a transaction-level model.
module tb_vn_lut_loader;
    logic       write_clk = 0, rst = 0, load_start = 0, load_abort = 0, host_valid = 0;
    logic [2:0] load_bank = 0;
    logic [3:0] host_data = 0;
    logic       host_ready, busy, done;
    logic [3:0] lut_in;
    logic [6:0] write_addr;
    logic [7:0] we_bank, bank_valid;
    vn_lut_loader dut (
        .write_clk(write_clk), .rst(rst), .load_start(load_start), .load_bank(load_bank),
        .load_abort(load_abort), .host_data(host_data), .host_valid(host_valid),
        .host_ready(host_ready), .lut_in(lut_in), .write_addr(write_addr), .we_bank(we_bank),
        .busy(busy), .done(done), .bank_valid(bank_valid)
    );
    always #5 write_clk = ~write_clk;
    int checks = 0, errors = 0;
    int wr_cnt = 0, done_cnt = 0;
    int bank_wr [8];
    logic [3:0] ram  [8][128];
    logic [3:0] hist [8][128];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    // Model: m_ld is the bank being loaded (-1 none), m_n the number of entries
    // taken so far, m_fin the bank whose load has just completed (-1 none).
    int         m_ld = -1, m_fin = -1, m_n = 0;
    logic [7:0] m_we = 0, m_valid = 0;
    logic [3:0] m_lut = 0;
    logic [6:0] m_addr = 0;
    always @(posedge write_clk or posedge rst) begin
        if (rst) begin
            m_ld <= -1; m_fin <= -1; m_n <= 0;
            m_we <= 0; m_lut <= 0; m_addr <= 0; m_valid <= 0;
        end else begin
            m_we <= 0;
            if (m_fin >= 0) begin
                m_valid[m_fin] <= 1'b1;
                m_fin <= -1;
            end else if (m_ld < 0) begin
                if (load_start) begin
                    m_ld <= int'(load_bank);
                    m_n <= 0;
                    m_valid[load_bank] <= 1'b0;
                end
            end else if (load_abort) begin
                m_ld <= -1;
            end else if (host_valid) begin
                m_we <= 8'(1) << m_ld;
                m_lut <= host_data;
                m_addr <= 7'(m_n);
                hist[m_ld][m_n] <= host_data;
                m_n <= m_n + 1;
                if (m_n == 127) begin
                    m_fin <= m_ld;
                    m_ld <= -1;
                end
            end
        end
    end
    initial forever begin
        @(negedge write_clk);
        chk("we_bank", we_bank, m_we);
        chk("lut_in", lut_in, m_lut);
        chk("write_addr", write_addr, m_addr);
        chk("bank_valid", bank_valid, m_valid);
        chk("busy", busy, (m_ld >= 0 || m_fin >= 0));
        chk("done", done, m_fin >= 0);
        chk("host_ready", host_ready, m_ld >= 0);
        chk("we_onehot", $countones(we_bank) <= 1, 1);
        if (done) begin
            chk("done_addr", write_addr, 127);
            chk("done_we", we_bank != 0, 1);
            done_cnt++;
        end
        if (we_bank != 0) wr_cnt++;
        for (int b = 0; b < 8; b++)
            if (we_bank[b]) begin
                ram[b][write_addr] = lut_in;
                bank_wr[b]++;
            end
    end
    task automatic tick;
        @(posedge write_clk);
        #1;
    endtask
    task automatic cmp_bank(input int b);
        int bad = 0;
        for (int a = 0; a < 128; a++) if (ram[b][a] !== hist[b][a]) bad++;
        chk("ram_vs_model", bad, 0);
    endtask
    // vp: valid percentage, or -1 for strict toggling. dmode 0: data = addr mod 16.
    task automatic do_load(input int b, input int vp, input int dmode, input int abort_at,
                           input int rst_at, input bit stray);
        int xf = 0;
        load_start = 1;
        load_bank = 3'(b);
        load_abort = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        tick;
        load_start = 0;
        load_abort = 0;
        for (int k = 0; k < 4000 && xf < 128; k++) begin
            bit v;
            v = vp == 100 ? 1'b1 : vp == -1 ? (k % 2 == 0) : ($urandom_range(0, 99) < vp);
            host_valid = v;
            host_data = dmode == 0 ? 4'(xf % 16) : 4'($urandom);
            if (xf == abort_at || xf == rst_at) begin
                if (xf == rst_at) begin
                    rst = 1;
                    #1;
                    chk("rst_bank_valid", bank_valid, 0);
                    chk("rst_we_bank", we_bank, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_addr", write_addr, 0);
                end else load_abort = 1;
                tick;
                rst = 0;
                load_abort = 0;
                host_valid = 0;
                return;
            end
            load_start = stray && (k % 37 == 5);
            if (stray) load_bank = 3'($urandom);
            tick;
            load_start = 0;
            if (v) xf++;
        end
        host_valid = 0;
        load_start = stray;
        load_abort = stray;
        load_bank = 3'($urandom);
        tick;
        load_start = 0;
        load_abort = 0;
    endtask
    initial begin
        int w0, d0, bad;
        #1 rst = 1;
        repeat (3) tick;
        chk("reset_bank_valid", bank_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ready", host_ready, 0);
        chk("reset_lut_in", lut_in, 0);
        rst = 0;
        tick;
        w0 = wr_cnt; d0 = done_cnt;
        do_load(3, 100, 0, -1, -1, 0);
        chk("full_writes", wr_cnt - w0, 128);
        chk("full_done", done_cnt - d0, 1);
        chk("full_valid", bank_valid, 8'h08);
        bad = 0;
        for (int a = 0; a < 128; a++) if (ram[3][a] !== 4'(a % 16)) bad++;
        chk("full_pattern", bad, 0);
        chk("full_last", ram[3][127], 15);
        w0 = wr_cnt; d0 = done_cnt;
        do_load(3, -1, 1, -1, -1, 0);
        chk("toggle_writes", wr_cnt - w0, 128);
        chk("toggle_done", done_cnt - d0, 1);
        chk("toggle_valid", bank_valid, 8'h08);
        cmp_bank(3);
        w0 = wr_cnt;
        do_load(5, 100, 1, 50, -1, 0);
        chk("abort_writes", wr_cnt - w0, 50);
        chk("abort_valid", bank_valid, 8'h08);
        chk("abort_idle", busy, 0);
        do_load(5, 100, 1, -1, -1, 0);
        chk("reload_valid", bank_valid, 8'h28);
        cmp_bank(5);
        w0 = bank_wr[1]; d0 = bank_wr[2];
        do_load(2, 100, 1, -1, -1, 1);
        chk("stray_bank1", bank_wr[1] - w0, 0);
        chk("stray_bank2", bank_wr[2] - d0, 128);
        chk("stray_valid", bank_valid, 8'h2C);
        w0 = wr_cnt;
        do_load(6, 100, 1, -1, 100, 0);
        // The 100th write is overtaken by the reset within its own cycle.
        chk("rst_writes", wr_cnt - w0, 99);
        chk("rst_valid_after", bank_valid, 0);
        d0 = done_cnt;
        for (int b = 0; b < 8; b++) do_load(b, 100, 1, -1, -1, 0);
        chk("b2b_done", done_cnt - d0, 8);
        chk("b2b_valid", bank_valid, 8'hFF);
        for (int b = 0; b < 8; b++) cmp_bank(b);
        for (int it = 0; it < 20; it++) begin
            int ab, rs;
            ab = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 127)) : -1;
            rs = $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 127)) : -1;
            do_load(int'($urandom_range(0, 7)), int'($urandom_range(20, 100)), 1, ab, rs, 1);
            repeat ($urandom_range(0, 3)) begin
                host_valid = 1'($urandom);
                load_abort = 1'($urandom);
                tick;
            end
            host_valid = 0;
            load_abort = 0;
        end
        tick;
        for (int b = 0; b < 8; b++) if (bank_valid[b]) cmp_bank(b);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vn_lut_loader.md
VN_LUT_LOADER -- requirements
Module: vn_lut_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, giving the quantised LUT entry width.
REQ-002 The block SHALL have parameter ADDR_W, default 7, giving the LUT address width (128 entries).
REQ-003 The block SHALL have parameter BANK_NUM, default 8, giving the number of LUT banks (one per decoding iteration).
REQ-004 write_clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 load_start  input  1  single-cycle request to begin loading one bank.
REQ-007 load_bank  input  clog2(BANK_NUM)  target bank, sampled only when load_start is accepted.
REQ-008 load_abort  input  1  terminates an in-progress load.
REQ-009 host_data  input  DATA_W  LUT entry from the host stream.
REQ-010 host_valid  input  1  host_data is valid.
REQ-011 host_ready  output  1  block accepts host_data this cycle.
REQ-012 lut_in  output  DATA_W  registered write data to the LUT RAMs.
REQ-013 write_addr  output  ADDR_W  registered write address to the LUT RAMs.
REQ-014 we_bank  output  BANK_NUM  registered, one-hot-or-zero write enable, one bit per bank.
REQ-015 busy  output  1  high in LOAD and DONE.
REQ-016 done  output  1  single-cycle completion pulse.
REQ-017 bank_valid  output  BANK_NUM  per-bank flag: bank fully loaded, safe to read.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, LOAD and DONE.
REQ-019 In IDLE, load_start=1 SHALL latch load_bank, clear cnt to 0, clear bank_valid[load_bank], and go to LOAD on the next edge.
REQ-020 In LOAD, host_ready SHALL be 1; in IDLE and DONE it SHALL be 0 (host_ready is combinational on state only).
REQ-021 A transfer SHALL occur when host_valid=1 and host_ready=1 in the same cycle.
REQ-022 On a transfer in cycle t, cycle t+1 SHALL show lut_in=host_data(t), write_addr=cnt(t) and we_bank = one-hot of the latched bank; cnt SHALL then increment.
REQ-023 In a cycle with no transfer, we_bank SHALL be 0 in the following cycle, and lut_in/write_addr SHALL hold their values.
REQ-024 A transfer at cnt = 2^ADDR_W-1 SHALL move the FSM to DONE; cnt SHALL wrap to 0.
REQ-025 DONE SHALL last exactly one cycle; in it done=1 (coincident with the final we_bank pulse); the next state SHALL be IDLE.
REQ-026 bank_valid[bank] SHALL be set on the DONE->IDLE edge, i.e. visible from the first IDLE cycle.
REQ-027 load_start in LOAD or DONE SHALL be ignored.
REQ-028 load_abort=1 in LOAD SHALL force IDLE on the next edge, with no transfer that cycle and bank_valid[bank] left 0; load_abort in IDLE or DONE SHALL be ignored.
REQ-029 load_abort and load_start asserted together in IDLE: the start SHALL win.
REQ-030 Bubbles (host_valid=0) SHALL be tolerated indefinitely with no timeout.
REQ-031 A bank not being loaded SHALL keep its bank_valid bit unchanged.
REQ-032 At most one we_bank bit SHALL ever be 1.

Reset
REQ-033 While rst=1: state=IDLE, cnt=0, lut_in=0, write_addr=0, we_bank=0, busy=0, done=0, bank_valid=0 (all banks), host_ready=0.
REQ-034 rst asserted mid-load SHALL abandon the load immediately, with no further we_bank pulse; the bank SHALL need a fresh load_start.

Verification
REQ-035 Load bank 3 with host_valid held high and data = addr mod 16 -> 128 consecutive we_bank=8'h08 pulses with write_addr 0..127 and lut_in 0..15 repeating; done pulses with the addr-127 write; bank_valid=8'h08 next cycle.
REQ-036 Same load with host_valid toggling every other cycle -> still exactly 128 writes in order; the done cycle is delayed accordingly; no we_bank during bubbles.
REQ-037 load_abort after 50 transfers to bank 5 -> state IDLE, bank_valid[5]=0, no further writes; a subsequent full load of bank 5 starts at write_addr 0.
REQ-038 load_start to bank 1 issued mid-load of bank 2 -> ignored; all 128 writes go to we_bank[2] only.
REQ-039 rst pulse at transfer 100 -> all outputs at reset values at once, bank_valid=0 including previously loaded banks.
REQ-040 Load banks 0..7 back to back, each load_start in the first IDLE cycle after done -> bank_valid ends 8'hFF; exactly one DONE cycle per bank.
